sram_frame_reader: RTL and testbench

Read-side counterpart of the flash-to-SRAM framebuffer loader. Once the loader has filled SRAM, this block streams the 640x480 8-bit framebuffer back out of the 16-bit SRAM, one byte per pixel. It splits each word into its two byte lanes and presents bytes to the VGA pixel pipeline through a valid/ready handshake, buffered by a small byte FIFO. It owns the SRAM port whenever the loader has finished.

---
 rtl/sram_fb_pkg.sv | 26 ++
 rtl/sram_frame_reader_if.sv | 43 ++++
 rtl/sram_frame_reader_byte_fifo.sv | 75 +++++++
 rtl/sram_frame_reader.sv | 113 +++++++++++
 tb/tb_sram_frame_reader.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_fb_pkg.sv
`default_nettype none
// ============================================================================
// sram_fb_pkg : framebuffer constants, SRAM geometry and reader FSM states
// Rev 1.0
// ============================================================================
package sram_fb_pkg;

  localparam int FRAME_BYTES_DEF = 307200;
  localparam int FRAME_WORDS     = FRAME_BYTES_DEF / 2;
  localparam int SRAM_AW         = 18;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    CAPTURE = 2'd2
  } rd_state_e;

  function automatic logic [SRAM_AW-1:0] next_word_addr(
    input logic [SRAM_AW-1:0] addr,
    input logic [SRAM_AW-1:0] last
  );
    return (addr == last) ? '0 : addr + SRAM_AW'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_frame_reader_if.sv
`default_nettype none
// ============================================================================
// sram_rd_if / pix_stream_if : SRAM word port and pixel byte stream bundles
// Rev 1.0
// ============================================================================
interface sram_rd_if;
  import sram_fb_pkg::*;

  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_rdata;
  logic               sram_oe;
  logic               sram_we;
  logic               sram_ce;
  logic               sram_ub;
  logic               sram_lb;

  modport master (
    output sram_addr, sram_oe, sram_we, sram_ce, sram_ub, sram_lb,
    input  sram_rdata
  );

  modport slave (
    input  sram_addr, sram_oe, sram_we, sram_ce, sram_ub, sram_lb,
    output sram_rdata
  );
endinterface

interface pix_stream_if;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;

  modport master (
    output pix_data, pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data, pix_valid,
    output pix_ready
  );
endinterface
`default_nettype wire

// File: rtl/sram_frame_reader_byte_fifo.sv
`default_nettype none
// ============================================================================
// byte_fifo : byte FIFO with 2-byte push, 1-byte pop and synchronous flush
// Rev 1.0
// ============================================================================
module byte_fifo #(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  input  wire logic          flush,
  input  wire logic          push2,
  input  wire logic [15:0]   wdata,
  input  wire logic          pop,
  output logic      [7:0]    rdata,
  output logic               valid,
  output logic      [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop_ok;

  assign pop_ok = pop & (cnt_q != '0);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      // Low lane lands first so it is popped first.
      if (push2) begin
        mem_d[wr_q]          = wdata[7:0];
        mem_d[wr_q + AW'(1)] = wdata[15:8];
        wr_d                 = wr_q + AW'(2);
      end
      if (pop_ok) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + (push2 ? CW'(2) : CW'(0)) - (pop_ok ? CW'(1) : CW'(0));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid = (cnt_q != '0);
  assign rdata = valid ? mem_q[rd_q] : 8'h00;
  assign count = cnt_q;

endmodule
`default_nettype wire

// File: rtl/sram_frame_reader.sv
`default_nettype none
// ============================================================================
// sram_frame_reader : streams the SRAM framebuffer out as one byte per pixel
// Rev 1.0
// ============================================================================
module sram_frame_reader
  import sram_fb_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int FIFO_DEPTH  = 8
) (
  input  wire logic  clk,
  input  wire logic  reset_n,
  input  wire logic  enable,
  input  wire logic  frame_start,
  sram_rd_if.master  sram,
  pix_stream_if.master pix,
  output logic       underflow
);

  localparam int                 CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]      DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [SRAM_AW-1:0] LAST_WORD = SRAM_AW'(FRAME_BYTES / 2 - 1);

  rd_state_e          state_q, state_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic               oe_q, oe_d;
  logic               underflow_q, underflow_d;

  logic               push2;
  logic               pop;
  logic [CW-1:0]      fifo_count;
  logic [CW-1:0]      free;
  logic [7:0]         fifo_data;
  logic               fifo_valid;

  // Free space is taken before this cycle's pop, so a push can never overflow.
  assign free = DEPTH_C - fifo_count;
  assign pop  = fifo_valid & pix.pix_ready & ~frame_start;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    push2       = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && free >= CW'(2)) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        push2   = 1'b1;
        addr_d  = next_word_addr(addr_q, LAST_WORD);
        state_d = (enable && free >= CW'(4)) ? ADDR : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (frame_start) begin
      state_d = IDLE;
      addr_d  = '0;
      push2   = 1'b0;
    end
    oe_d        = (state_d == IDLE);
    underflow_d = frame_start ? 1'b0
                : (underflow_q | (enable & pix.pix_ready & ~fifo_valid));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      oe_q        <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      oe_q        <= oe_d;
      underflow_q <= underflow_d;
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (frame_start),
    .push2   (push2),
    .wdata   (sram.sram_rdata),
    .pop     (pop),
    .rdata   (fifo_data),
    .valid   (fifo_valid),
    .count   (fifo_count)
  );

  assign sram.sram_addr = addr_q;
  assign sram.sram_oe   = oe_q;
  assign sram.sram_we   = 1'b1;
  assign sram.sram_ce   = 1'b0;
  assign sram.sram_ub   = 1'b0;
  assign sram.sram_lb   = 1'b0;

  assign pix.pix_data   = fifo_data;
  assign pix.pix_valid  = fifo_valid;
  assign underflow      = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_frame_reader.sv
`default_nettype none
// ============================================================================
// tb_sram_frame_reader : scoreboard bench for the SRAM frame reader
// Rev 1.0
// ============================================================================
module tb_sram_frame_reader;

  localparam int          FB     = 512;
  localparam logic [17:0] LAST_W = 18'(FB / 2 - 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic frame_start = 1'b0;
  logic underflow;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  sram_rd_if    sram_bus ();
  pix_stream_if pix_bus ();

  sram_frame_reader #(
    .FRAME_BYTES (FB),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .frame_start (frame_start),
    .sram        (sram_bus),
    .pix         (pix_bus),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  // Directed SRAM contents; other words hold their own byte addresses.
  function automatic logic [15:0] word_at(input logic [17:0] w);
    logic [17:0] b;
    b = w << 1;
    if (w == 18'd0)   return 16'hBBAA;
    if (w == 18'd1)   return 16'hDDCC;
    if (w == LAST_W)  return 16'h2211;
    return {b[7:0] + 8'd1, b[7:0]};
  endfunction

  assign sram_bus.sram_rdata = word_at(sram_bus.sram_addr);

  task automatic push_words(input int first, input int n);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = word_at(18'(first + i));
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic end_phase(input string name, input int left);
    chk({name, "_left"}, 32'(exp_q.size()), 32'(left));
    pix_bus.pix_ready = 1'b0;
    enable            = 1'b0;
    frame_start       = 1'b1;
    exp_q.delete();
    tick();
    frame_start = 1'b0;
  endtask

  // Scoreboard monitor: every accepted byte must match the queue head.
  always @(negedge clk) begin
    if (reset_n && pix_bus.pix_valid && pix_bus.pix_ready && !frame_start) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pix_extra: got %02h with nothing expected at %0t", pix_bus.pix_data, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (pix_bus.pix_data !== e) begin
          n_err++;
          $display("FAIL pix_data: got %02h expected %02h at %0t", pix_bus.pix_data, e, $time);
        end
      end
    end
  end

  initial begin
    pix_bus.pix_ready = 1'b0;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe_held", 32'(sram_bus.sram_oe), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_oe",    32'(sram_bus.sram_oe),   32'd1);
    chk("rst_we",    32'(sram_bus.sram_we),   32'd1);
    chk("rst_ce",    32'(sram_bus.sram_ce),   32'd0);
    chk("rst_ublb",  32'({sram_bus.sram_ub, sram_bus.sram_lb}), 32'd0);
    chk("rst_addr",  32'(sram_bus.sram_addr), 32'd0);
    chk("rst_valid", 32'(pix_bus.pix_valid),  32'd0);
    chk("rst_data",  32'(pix_bus.pix_data),   32'd0);
    chk("rst_uflow", 32'(underflow),          32'd0);

    // Basic stream with ready high from cycle 0: latency, address sequence, underflow
    tick();
    push_words(0, 50);
    enable            = 1'b1;
    pix_bus.pix_ready = 1'b1;
    @(negedge clk);
    chk("c0_oe", 32'(sram_bus.sram_oe), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("addr_seq", 32'(sram_bus.sram_addr), 32'((k - 1) / 2));
      if (k == 1) begin
        chk("c1_oe",    32'(sram_bus.sram_oe), 32'd0);
        chk("c1_uflow", 32'(underflow),        32'd1);
      end
      if (k == 2) chk("c2_valid", 32'(pix_bus.pix_valid), 32'd0);
      if (k == 3) chk("c3_valid", 32'(pix_bus.pix_valid), 32'd1);
    end
    repeat (34) @(negedge clk);
    chk("uflow_sticky", 32'(underflow), 32'd1);
    tick();
    end_phase("basic", 100 - 38);
    @(negedge clk);
    chk("fs_uflow", 32'(underflow),          32'd0);
    chk("fs_valid", 32'(pix_bus.pix_valid),  32'd0);
    chk("fs_addr",  32'(sram_bus.sram_addr), 32'd0);
    chk("fs_oe",    32'(sram_bus.sram_oe),   32'd1);

    // Backpressure: FIFO fills, reads stop at word 4, then drain in order
    tick();
    push_words(0, 20);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    chk("bp_oe",    32'(sram_bus.sram_oe),   32'd1);
    chk("bp_addr",  32'(sram_bus.sram_addr), 32'd4);
    chk("bp_valid", 32'(pix_bus.pix_valid),  32'd1);
    repeat (5) @(negedge clk);
    chk("bp_addr_frozen", 32'(sram_bus.sram_addr), 32'd4);
    tick();
    pix_bus.pix_ready = 1'b1;
    repeat (30) @(negedge clk);
    chk("bp_uflow", 32'(underflow), 32'd0);
    tick();
    end_phase("bp", 10);

    // frame_start during CAPTURE of word 100 (cycle 202)
    tick();
    push_words(0, 100);
    enable            = 1'b1;
    pix_bus.pix_ready = 1'b1;
    repeat (202) tick();
    chk("fs100_addr", 32'(sram_bus.sram_addr), 32'd100);
    chk("fs100_oe",   32'(sram_bus.sram_oe),   32'd0);
    exp_q.delete();
    push_words(0, 10);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    chk("fs100_valid", 32'(pix_bus.pix_valid),  32'd0);
    chk("fs100_addr0", 32'(sram_bus.sram_addr), 32'd0);
    chk("fs100_uflow", 32'(underflow),          32'd0);
    repeat (2) @(negedge clk);
    chk("fs100_n3_valid", 32'(pix_bus.pix_valid), 32'd0);
    @(negedge clk);
    chk("fs100_n4_valid", 32'(pix_bus.pix_valid), 32'd1);
    repeat (9) @(negedge clk);
    tick();
    end_phase("fs100", 10);

    // Address wrap: last word 2211 then word 0 again
    tick();
    push_words(0, FB / 2);
    push_words(0, 15);
    enable            = 1'b1;
    pix_bus.pix_ready = 1'b1;
    repeat (512) tick();
    chk("wrap_last_addr", 32'(sram_bus.sram_addr), 32'(LAST_W));
    tick();
    chk("wrap_addr0", 32'(sram_bus.sram_addr), 32'd0);
    repeat (27) tick();
    end_phase("wrap", 542 - 537);

    // Asynchronous reset in the middle of a stream
    tick();
    push_words(0, 50);
    enable            = 1'b1;
    pix_bus.pix_ready = 1'b1;
    repeat (20) tick();
    chk("mid_oe", 32'(sram_bus.sram_oe), 32'd0);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_oe",    32'(sram_bus.sram_oe),   32'd1);
    chk("arst_addr",  32'(sram_bus.sram_addr), 32'd0);
    chk("arst_valid", 32'(pix_bus.pix_valid),  32'd0);
    chk("arst_data",  32'(pix_bus.pix_data),   32'd0);
    chk("arst_uflow", 32'(underflow),          32'd0);
    enable            = 1'b0;
    pix_bus.pix_ready = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_oe",   32'(sram_bus.sram_oe),   32'd1);
    chk("post_rst_addr", 32'(sram_bus.sram_addr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
